// File: rtl/i2c_target.sv
// i2c_target
// I2C target (slave) front-end with a small 8-bit register file.
// The SCL/SDA pad levels are oversampled on clk. The block detects START and
// STOP, matches a 7-bit address, and supports three operations: a pointer
// write, register writes and register reads. Reads and writes auto-increment
// the pointer. The block never stretches SCL.
//
// Ports
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-low reset
//   scl_i  : SCL pad level (asynchronous to clk)
//   scl_o  : SCL pull-down enable, always 0
//   sda_i  : SDA pad level (asynchronous to clk)
//   sda_o  : SDA pull-down enable (1 = drive SDA low)
module i2c_target #(
    parameter logic [6:0] ADDRESS  = 7'h4B,
    parameter int         NUM_REGS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_i,
    output logic scl_o,
    input  logic sda_i,
    output logic sda_o
);

    localparam int PTR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WRITE,
        WRITE_ACK,
        READ,
        READ_ACK
    } state_t;

    state_t            state, state_n;
    logic [2:0]        scl_sync, sda_sync;
    logic [3:0]        bit_cnt, bit_cnt_n;
    logic [7:0]        shift, shift_n;
    logic [PTR_W-1:0]  ptr, ptr_n;
    logic              is_ptr, is_ptr_n;
    logic              sda_n;
    logic              reg_we;
    logic [7:0]        rx_byte;
    logic [7:0]        rd_byte;
    logic [7:0]        regs [NUM_REGS];

    logic scl_rise, scl_fall, scl_high, start_det, stop_det;

    assign scl_o = 1'b0;

    // Two synchronizer stages plus one history stage per pad. The stages
    // reset to 1 (an idle bus), so releasing reset cannot fake an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync <= 3'b111;
            sda_sync <= 3'b111;
        end else begin
            scl_sync <= {scl_sync[1:0], scl_i};
            sda_sync <= {sda_sync[1:0], sda_i};
        end
    end

    assign scl_rise  =  scl_sync[1] & ~scl_sync[2];
    assign scl_fall  = ~scl_sync[1] &  scl_sync[2];
    assign scl_high  =  scl_sync[1] &  scl_sync[2];
    assign start_det =  scl_high & sda_sync[2] & ~sda_sync[1];
    assign stop_det  =  scl_high & ~sda_sync[2] & sda_sync[1];

    assign rx_byte = {shift[6:0], sda_sync[1]};
    assign rd_byte = regs[ptr];

    // State register and the registered datapath of the protocol engine.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            ptr     <= '0;
            is_ptr  <= 1'b0;
            sda_o   <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            shift   <= shift_n;
            ptr     <= ptr_n;
            is_ptr  <= is_ptr_n;
            sda_o   <= sda_n;
        end
    end

    // The register file is written when a full data byte has been received.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (reg_we) begin
            regs[ptr] <= rx_byte;
        end
    end

    // Next-state logic. START and STOP override any bit handling.
    // In the ACK states, sda_o itself tracks the two halves of the ACK
    // window. The first SCL fall raises sda_o. The second SCL fall lowers
    // it again and leaves the state.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        ptr_n     = ptr;
        is_ptr_n  = is_ptr;
        sda_n     = sda_o;
        reg_we    = 1'b0;

        if (stop_det) begin
            state_n   = IDLE;
            bit_cnt_n = '0;
            sda_n     = 1'b0;
        end else if (start_det) begin
            state_n   = ADDR;
            bit_cnt_n = '0;
            sda_n     = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    sda_n = 1'b0;
                end

                ADDR: begin
                    if (scl_rise) begin
                        shift_n   = rx_byte;
                        bit_cnt_n = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            state_n = (rx_byte[7:1] == ADDRESS) ? ADDR_ACK : IDLE;
                        end
                    end
                end

                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_o) begin
                            sda_n = 1'b1;
                        end else if (shift[0]) begin
                            // Read: the fall that ends the ACK also presents bit 7.
                            state_n   = READ;
                            sda_n     = ~rd_byte[7];
                            shift_n   = {rd_byte[6:0], 1'b0};
                            bit_cnt_n = 4'd1;
                        end else begin
                            state_n   = WRITE;
                            sda_n     = 1'b0;
                            bit_cnt_n = '0;
                            is_ptr_n  = 1'b1;
                        end
                    end
                end

                WRITE: begin
                    if (scl_rise) begin
                        shift_n   = rx_byte;
                        bit_cnt_n = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            state_n = WRITE_ACK;
                            if (is_ptr) begin
                                ptr_n    = rx_byte[PTR_W-1:0];
                                is_ptr_n = 1'b0;
                            end else begin
                                reg_we = 1'b1;
                                ptr_n  = ptr + PTR_W'(1);
                            end
                        end
                    end
                end

                WRITE_ACK: begin
                    if (scl_fall) begin
                        if (!sda_o) begin
                            sda_n = 1'b1;
                        end else begin
                            state_n   = WRITE;
                            sda_n     = 1'b0;
                            bit_cnt_n = '0;
                        end
                    end
                end

                READ: begin
                    if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            state_n = READ_ACK;
                            sda_n   = 1'b0;
                            ptr_n   = ptr + PTR_W'(1);
                        end else begin
                            sda_n     = ~shift[7];
                            shift_n   = {shift[6:0], 1'b0};
                            bit_cnt_n = bit_cnt + 4'd1;
                        end
                    end
                end

                READ_ACK: begin
                    if (scl_rise) begin
                        if (!sda_sync[1]) begin
                            state_n   = READ;
                            shift_n   = rd_byte;
                            bit_cnt_n = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end

                default: begin
                    state_n = IDLE;
                    sda_n   = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target
// Testbench for i2c_target. It models an I2C master driving an open-drain
// bus with each SCL phase lasting 10 clk periods. A table of bus operations
// drives the stimulus. When an operation starts, its expected result is
// pushed onto a scoreboard queue. The result is popped and compared when
// the operation completes. Reset and STOP-mid-byte are hand-written
// sequences.
module tb_i2c_target;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic scl_m = 1'b1;
    logic sda_m_low = 1'b0;
    logic scl_o;
    logic sda_o;
    logic sda_line;

    // Open-drain SDA: low if either the master or the target pulls it down.
    assign sda_line = ~(sda_m_low | sda_o);

    i2c_target #(
        .ADDRESS  (7'h4B),
        .NUM_REGS (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .scl_i (scl_m),
        .scl_o (scl_o),
        .sda_i (sda_line),
        .sda_o (sda_o)
    );

    always #5 clk = ~clk;

    typedef enum {OP_START, OP_STOP, OP_WR, OP_RD} op_t;

    // For OP_WR, ack is 1 when the target must ACK the byte.
    // For OP_RD, data is the expected byte and ack is 1 when the master ACKs.
    typedef struct {
        op_t        op;
        logic [7:0] data;
        logic       ack;
    } vec_t;

    typedef struct {
        string      name;
        logic [8:0] value;
    } sb_item_t;

    vec_t     vecs[$];
    sb_item_t sb_q[$];
    int       n_checks = 0;
    int       n_pass   = 0;

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_value(input string name, input logic [8:0] v);
        sb_item_t item;
        item.name  = name;
        item.value = v;
        sb_q.push_back(item);
    endtask

    task automatic checkOutput(input logic [8:0] actual);
        sb_item_t item;
        n_checks++;
        if (sb_q.size() == 0) begin
            $display("[TB] FAIL scoreboard_empty actual=%h", actual);
        end else begin
            item = sb_q.pop_front();
            if (actual === item.value) begin
                n_pass++;
            end else begin
                $display("[TB] FAIL %s actual=%h expected=%h", item.name, actual, item.value);
            end
        end
    endtask

    task automatic bus_start();
        wait_clk(5);
        sda_m_low = 1'b0;
        wait_clk(5);
        scl_m = 1'b1;
        wait_clk(10);
        sda_m_low = 1'b1;
        wait_clk(10);
        scl_m = 1'b0;
    endtask

    task automatic bus_stop();
        wait_clk(5);
        sda_m_low = 1'b1;
        wait_clk(5);
        scl_m = 1'b1;
        wait_clk(10);
        sda_m_low = 1'b0;
        wait_clk(10);
    endtask

    // Sends n bits MSB first. Flags any target drive seen while SCL is high.
    task automatic write_bits(input logic [7:0] data, input int n, output logic drove);
        drove = 1'b0;
        for (int i = 0; i < n; i++) begin
            wait_clk(5);
            sda_m_low = ~data[3'(7 - i)];
            wait_clk(5);
            scl_m = 1'b1;
            wait_clk(5);
            if (sda_o) drove = 1'b1;
            wait_clk(5);
            scl_m = 1'b0;
        end
    endtask

    task automatic write_byte(input logic [7:0] data, output logic [8:0] obs);
        logic drove;
        logic line;
        write_bits(data, 8, drove);
        wait_clk(5);
        sda_m_low = 1'b0;
        wait_clk(5);
        scl_m = 1'b1;
        wait_clk(5);
        line = sda_line;
        wait_clk(5);
        scl_m = 1'b0;
        obs = {7'd0, drove, line};
    endtask

    task automatic read_byte(input logic m_ack, output logic [8:0] obs);
        logic [7:0] b;
        logic       rel;
        b = '0;
        for (int i = 0; i < 8; i++) begin
            wait_clk(5);
            sda_m_low = 1'b0;
            wait_clk(5);
            scl_m = 1'b1;
            wait_clk(5);
            b = {b[6:0], sda_line};
            wait_clk(5);
            scl_m = 1'b0;
        end
        wait_clk(5);
        sda_m_low = m_ack;
        wait_clk(5);
        scl_m = 1'b1;
        wait_clk(5);
        rel = sda_o;
        wait_clk(5);
        scl_m = 1'b0;
        obs = {b, rel};
    endtask

    task automatic applyStimulus(input vec_t v);
        logic [8:0] obs;
        case (v.op)
            OP_START: bus_start();
            OP_STOP: begin
                expect_value("stop_release", 9'd0);
                bus_stop();
                checkOutput({8'd0, sda_o});
            end
            OP_WR: begin
                expect_value($sformatf("wr_%02h_ack", v.data), {7'd0, 1'b0, ~v.ack});
                write_byte(v.data, obs);
                checkOutput(obs);
            end
            OP_RD: begin
                expect_value($sformatf("rd_%02h", v.data), {v.data, 1'b0});
                read_byte(v.ack, obs);
                checkOutput(obs);
            end
            default: ;
        endcase
    endtask

    function automatic void add_vec(input op_t op, input logic [7:0] data, input logic ack);
        vec_t v;
        v.op   = op;
        v.data = data;
        v.ack  = ack;
        vecs.push_back(v);
    endfunction

    task automatic do_op(input op_t op, input logic [7:0] data, input logic ack);
        vec_t v;
        v.op   = op;
        v.data = data;
        v.ack  = ack;
        applyStimulus(v);
    endtask

    // Watchdog: the bench never waits on the DUT, but guard against a runaway.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic drove;

        // Write ptr 1, then A5 -> reg1 and 3C -> reg2.
        add_vec(OP_START, 8'h00, 1'b0);
        add_vec(OP_WR,    8'h96, 1'b1);
        add_vec(OP_WR,    8'h01, 1'b1);
        add_vec(OP_WR,    8'hA5, 1'b1);
        add_vec(OP_WR,    8'h3C, 1'b1);
        add_vec(OP_STOP,  8'h00, 1'b0);
        // Repeated-START read from ptr 1: master ACKs A5, then NACKs 3C.
        add_vec(OP_START, 8'h00, 1'b0);
        add_vec(OP_WR,    8'h96, 1'b1);
        add_vec(OP_WR,    8'h01, 1'b1);
        add_vec(OP_START, 8'h00, 1'b0);
        add_vec(OP_WR,    8'h97, 1'b1);
        add_vec(OP_RD,    8'hA5, 1'b1);
        add_vec(OP_RD,    8'h3C, 1'b0);
        add_vec(OP_STOP,  8'h00, 1'b0);
        // Wrong address: no ACK, and the following byte is ignored.
        add_vec(OP_START, 8'h00, 1'b0);
        add_vec(OP_WR,    8'hA0, 1'b0);
        add_vec(OP_WR,    8'h55, 1'b0);
        add_vec(OP_STOP,  8'h00, 1'b0);
        // Pointer wrap on write: reg3 = 11, reg0 = 22.
        add_vec(OP_START, 8'h00, 1'b0);
        add_vec(OP_WR,    8'h96, 1'b1);
        add_vec(OP_WR,    8'h03, 1'b1);
        add_vec(OP_WR,    8'h11, 1'b1);
        add_vec(OP_WR,    8'h22, 1'b1);
        add_vec(OP_STOP,  8'h00, 1'b0);
        // Read from ptr 3 with NACK after the first byte.
        add_vec(OP_START, 8'h00, 1'b0);
        add_vec(OP_WR,    8'h96, 1'b1);
        add_vec(OP_WR,    8'h03, 1'b1);
        add_vec(OP_START, 8'h00, 1'b0);
        add_vec(OP_WR,    8'h97, 1'b1);
        add_vec(OP_RD,    8'h11, 1'b0);
        add_vec(OP_STOP,  8'h00, 1'b0);
        // Pointer wrap on read: reg3, reg0, reg1.
        add_vec(OP_START, 8'h00, 1'b0);
        add_vec(OP_WR,    8'h96, 1'b1);
        add_vec(OP_WR,    8'h03, 1'b1);
        add_vec(OP_START, 8'h00, 1'b0);
        add_vec(OP_WR,    8'h97, 1'b1);
        add_vec(OP_RD,    8'h11, 1'b1);
        add_vec(OP_RD,    8'h22, 1'b1);
        add_vec(OP_RD,    8'hA5, 1'b0);
        add_vec(OP_STOP,  8'h00, 1'b0);

        $display("[TB] reset");
        reset = 1'b0;
        wait_clk(4);
        expect_value("reset_outputs", 9'd0);
        checkOutput({7'd0, scl_o, sda_o});
        reset = 1'b1;
        wait_clk(10);

        $display("[TB] table vectors: %0d", vecs.size());
        foreach (vecs[i]) applyStimulus(vecs[i]);

        // A STOP after 4 bits of a data byte must leave reg2 untouched.
        $display("[TB] STOP mid-byte");
        do_op(OP_START, 8'h00, 1'b0);
        do_op(OP_WR,    8'h96, 1'b1);
        do_op(OP_WR,    8'h02, 1'b1);
        expect_value("partial_no_drive", 9'd0);
        write_bits(8'hF0, 4, drove);
        checkOutput({8'd0, drove});
        do_op(OP_STOP,  8'h00, 1'b0);
        do_op(OP_START, 8'h00, 1'b0);
        do_op(OP_WR,    8'h96, 1'b1);
        do_op(OP_WR,    8'h02, 1'b1);
        do_op(OP_START, 8'h00, 1'b0);
        do_op(OP_WR,    8'h97, 1'b1);
        do_op(OP_RD,    8'h3C, 1'b0);
        do_op(OP_STOP,  8'h00, 1'b0);

        // Assert reset while the target is driving an address ACK.
        $display("[TB] reset during ACK");
        do_op(OP_START, 8'h00, 1'b0);
        write_bits(8'h96, 8, drove);
        wait_clk(5);
        sda_m_low = 1'b0;
        wait_clk(5);
        scl_m = 1'b1;
        wait_clk(5);
        expect_value("ack_before_reset", 9'd1);
        checkOutput({8'd0, sda_o});
        reset = 1'b0;
        #1;
        expect_value("reset_mid_byte", 9'd0);
        checkOutput({7'd0, scl_o, sda_o});
        wait_clk(4);
        reset = 1'b1;
        wait_clk(10);
        // Registers must be cleared: reg0 and reg3 read back as 00.
        do_op(OP_START, 8'h00, 1'b0);
        do_op(OP_WR,    8'h96, 1'b1);
        do_op(OP_WR,    8'h00, 1'b1);
        do_op(OP_START, 8'h00, 1'b0);
        do_op(OP_WR,    8'h97, 1'b1);
        do_op(OP_RD,    8'h00, 1'b0);
        do_op(OP_STOP,  8'h00, 1'b0);
        do_op(OP_START, 8'h00, 1'b0);
        do_op(OP_WR,    8'h96, 1'b1);
        do_op(OP_WR,    8'h03, 1'b1);
        do_op(OP_START, 8'h00, 1'b0);
        do_op(OP_WR,    8'h97, 1'b1);
        do_op(OP_RD,    8'h00, 1'b0);
        do_op(OP_STOP,  8'h00, 1'b0);

        if (sb_q.size() != 0) begin
            n_checks++;
            $display("[TB] FAIL scoreboard_leftover actual=%0d expected=0", sb_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
